// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port word RAM for the load/store path with byte/half/word
//   access, byte-lane stores, signed/unsigned load extension and alignment/range faults.
// Latency: accept on edge N, rsp_valid high in the following cycle plus WAIT_STATES cycles.
// Backpressure: req_ready only in IDLE (one request outstanding); no response backpressure.
// Ports: clk/rst (sync, active-high); req_valid/req_ready handshake carrying req_write,
//   req_size, req_signed, req_addr, req_wdata; rsp_valid strobe with registered
//   rsp_rdata/rsp_fault that hold until the next response.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       wait_cnt;
  logic [31:0]      pend_rdata;
  logic             pend_fault;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             acc_fault;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      acc_result;

  // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign word_idx  = req_addr[IDX_W+1:2];

  always_comb begin
    acc_fault = 1'b0;
    if (req_size == 2'b11)                              acc_fault = 1'b1;
    if (req_size == 2'b01 && req_addr[0] != 1'b0)        acc_fault = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)     acc_fault = 1'b1;
    if ((req_addr >> 2) >= ADDR_WIDTH'(DEPTH_WORDS))     acc_fault = 1'b1;
  end

  // Stores and faults both return zero data; only a clean load returns RAM content.
  always_comb begin
    acc_result = 32'd0;
    if (!acc_fault && !req_write)
      acc_result = extract_load(mem[word_idx], req_size, req_signed, req_addr[1:0]);
  end

  // RAM is deliberately not reset; a committed store survives a later rst.
  always_ff @(posedge clk) begin
    if (accept && req_write && !acc_fault) begin
      case (req_size)
        2'b00:   mem[word_idx][{req_addr[1:0], 3'b000} +: 8]  <= req_wdata[7:0];
        2'b01:   mem[word_idx][{req_addr[1], 4'b0000} +: 16] <= req_wdata[15:0];
        default: mem[word_idx] <= req_wdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      rsp_rdata  <= 32'd0;
      rsp_fault  <= 1'b0;
      pend_rdata <= 32'd0;
      pend_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pend_rdata <= acc_result;
            pend_fault <= acc_fault;
            if (WAIT_STATES == 0) begin
              // No wait states: publish the result straight into the output registers.
              rsp_rdata <= acc_result;
              rsp_fault <= acc_fault;
              state     <= ST_RESP;
            end else begin
              wait_cnt <= 4'd0;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Outputs are only updated on entry to RESP so they hold the previous
          // response while the current access is waiting.
          if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            rsp_rdata <= pend_rdata;
            rsp_fault <= pend_fault;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: exercises two instances (WAIT_STATES 0 and 2) against a
//   byte-addressed reference memory kept in the bench.
// Index 0 of every bus drives the W=0 instance, index 1 the W=2 instance.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       req_valid, req_ready, req_write, req_signed, rsp_valid, rsp_fault;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  int tests = 0;
  int fails = 0;

  // Reference memory: plain byte array per instance, little-endian.
  logic [7:0] mb [2][1024];

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_fault(rsp_fault[0])
  );

  data_memory_ctrl #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_fault(rsp_fault[1])
  );

  function automatic void model_op(input int d, input bit wr, input bit [1:0] sz, input bit sg,
                                   input bit [31:0] a, input bit [31:0] wd,
                                   output logic [31:0] rd, output bit flt);
    int n;
    n   = 1 << sz;
    flt = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'd1024);
    rd  = '0;
    if (!flt) begin
      if (wr) begin
        for (int i = 0; i < n; i++) mb[d][a + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = mb[d][a + i];
        if (sg && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  task automatic drive(input int d, input bit wr, input bit [1:0] sz, input bit sg,
                       input bit [31:0] a, input bit [31:0] wd);
    req_write[d]  = wr;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
  endtask

  // One complete access: checks ready, latency, single pulse, busy window, data and fault.
  task automatic do_op(input int d, input bit wr, input bit [1:0] sz, input bit sg,
                       input bit [31:0] a, input bit [31:0] wd, input string nm,
                       output logic [31:0] got_rd, output logic got_f);
    int w;
    int first;
    int cnt;
    bit busy_bad;
    logic [31:0] erd;
    bit ef;
    w = (d == 0) ? 0 : 2;
    first = 0; cnt = 0; busy_bad = 1'b0;
    got_rd = 'x; got_f = 1'bx;
    model_op(d, wr, sz, sg, a, wd, erd, ef);
    @(negedge clk);
    drive(d, wr, sz, sg, a, wd);
    tests++;
    if (req_ready[d] !== 1'b1) begin
      fails++; $display("FAIL %s ready: got %b want 1", nm, req_ready[d]);
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      if (rsp_valid[d] === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first  = c;
          got_rd = rsp_rdata[d];
          got_f  = rsp_fault[d];
        end
      end
      if (c <= w + 1 && req_ready[d] !== 1'b0) busy_bad = 1'b1;
    end
    tests++;
    if (first != w + 1) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", nm, first, w + 1);
    end
    tests++;
    if (cnt != 1) begin
      fails++; $display("FAIL %s pulse_count: got %0d want 1", nm, cnt);
    end
    tests++;
    if (got_rd !== erd) begin
      fails++; $display("FAIL %s rdata: got %h want %h", nm, got_rd, erd);
    end
    tests++;
    if (got_f !== ef) begin
      fails++; $display("FAIL %s fault: got %b want %b", nm, got_f, ef);
    end
    tests++;
    if (busy_bad) begin
      fails++; $display("FAIL %s busy_ready: got ready high while busy want low", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_signed = '0; req_size = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (req_ready[d] !== 1'b0) begin fails++; $display("FAIL reset_ready%0d: got %b want 0", d, req_ready[d]); end
      tests++;
      if (rsp_valid[d] !== 1'b0) begin fails++; $display("FAIL reset_valid%0d: got %b want 0", d, rsp_valid[d]); end
      tests++;
      if (rsp_rdata[d] !== 32'd0) begin fails++; $display("FAIL reset_rdata%0d: got %h want 0", d, rsp_rdata[d]); end
      tests++;
      if (rsp_fault[d] !== 1'b0) begin fails++; $display("FAIL reset_fault%0d: got %b want 0", d, rsp_fault[d]); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (req_ready[d] !== 1'b1) begin fails++; $display("FAIL post_reset_ready%0d: got %b want 1", d, req_ready[d]); end
    end
  endtask

  // Give both RAMs known contents so every later load has a defined expectation.
  task automatic init_mem();
    logic [31:0] r; logic f;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        do_op(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "init", r, f);
  endtask

  task automatic test_store_load();
    logic [31:0] r; logic f;
    do_op(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "w0_store_word", r, f);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "w0_load_word", r, f);
    tests++;
    if (r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL w0_load_const: got %h want deadbeef", r); end
  endtask

  task automatic test_byte_sign();
    logic [31:0] r; logic f;
    do_op(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_0080, "store_byte", r, f);
    do_op(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, "load_byte_s", r, f);
    tests++;
    if (r !== 32'hFFFF_FF80) begin fails++; $display("FAIL byte_signed_const: got %h want ffffff80", r); end
    do_op(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, "load_byte_u", r, f);
    tests++;
    if (r !== 32'h0000_0080) begin fails++; $display("FAIL byte_unsigned_const: got %h want 00000080", r); end
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "load_word_after_byte", r, f);
    tests++;
    if (r !== 32'h80AD_BEEF) begin fails++; $display("FAIL word_after_byte_const: got %h want 80adbeef", r); end
    do_op(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_F00D, "store_half_hi", r, f);
    do_op(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, "load_half_s", r, f);
    tests++;
    if (r !== 32'hFFFF_F00D) begin fails++; $display("FAIL half_signed_const: got %h want fffff00d", r); end
  endtask

  task automatic test_faults();
    logic [31:0] r; logic f;
    do_op(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'd0, "fault_half_misaligned", r, f);
    tests++;
    if (f !== 1'b1) begin fails++; $display("FAIL fault_half_flag: got %b want 1", f); end
    do_op(0, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0, "fault_size11", r, f);
    tests++;
    if (f !== 1'b1) begin fails++; $display("FAIL fault_size_flag: got %b want 1", f); end
    do_op(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h1234_5678, "fault_range_store", r, f);
    tests++;
    if (f !== 1'b1 || r !== 32'd0) begin fails++; $display("FAIL fault_range_flag: got f=%b r=%h want f=1 r=0", f, r); end
    do_op(0, 1'b1, 2'd2, 1'b0, 32'h2, 32'hCAFE_CAFE, "fault_word_misaligned_store", r, f);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, "reread_0", r, f);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, "reread_10", r, f);
    tests++;
    if (r !== 32'h80AD_BEEF) begin fails++; $display("FAIL reread_10_const: got %h want 80adbeef", r); end
  endtask

  task automatic test_wait_states();
    logic [31:0] r; logic f;
    do_op(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5_1234, "w2_store", r, f);
    do_op(1, 1'b0, 2'd1, 1'b0, 32'h42, 32'd0, "w2_load_half", r, f);
    tests++;
    if (r !== 32'h0000_A5A5) begin fails++; $display("FAIL w2_half_const: got %h want 0000a5a5", r); end
    do_op(1, 1'b0, 2'd0, 1'b0, 32'h41, 32'd0, "w2_fault_free_byte", r, f);
    do_op(1, 1'b0, 2'd2, 1'b0, 32'h43, 32'd0, "w2_fault_word", r, f);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic f; logic [31:0] erd; bit ef;
    int seen;
    seen = 0;
    model_op(1, 1'b1, 2'd2, 1'b0, 32'h80, 32'h0BAD_F00D, erd, ef);
    @(negedge clk);
    drive(1, 1'b1, 2'd2, 1'b0, 32'h80, 32'h0BAD_F00D);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (req_ready[1] !== 1'b0) begin fails++; $display("FAIL midrst_ready_in_rst: got %b want 0", req_ready[1]); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) seen++;
      if (c == 0) begin
        tests++;
        if (req_ready[1] !== 1'b1) begin fails++; $display("FAIL midrst_ready_after: got %b want 1", req_ready[1]); end
      end
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL midrst_no_rsp: got %0d pulses want 0", seen); end
    do_op(1, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, "midrst_readback", r, f);
    tests++;
    if (r !== 32'h0BAD_F00D) begin fails++; $display("FAIL midrst_readback_const: got %h want 0badf00d", r); end
  endtask

  task automatic test_back_to_back();
    bit [31:0]   addrs [4];
    logic [31:0] exp_q [$];
    int          acc_cyc [$];
    int          issued;
    int          got;
    logic [31:0] e;
    bit          ef;
    bit          acc;
    issued = 0; got = 0;
    for (int i = 0; i < 4; i++) addrs[i] = 32'($urandom_range(0, 255) * 4);
    @(negedge clk);
    model_op(0, 1'b0, 2'd2, 1'b0, addrs[0], 32'd0, e, ef);
    exp_q.push_back(e);
    drive(0, 1'b0, 2'd2, 1'b0, addrs[0], 32'd0);
    issued = 1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid[0] === 1'b1) begin
        got++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_rdata: got %h want no response", rsp_rdata[0]);
        end else begin
          if (rsp_rdata[0] !== exp_q[0]) begin
            fails++; $display("FAIL b2b_rdata: got %h want %h", rsp_rdata[0], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      acc = (req_valid[0] === 1'b1) && (req_ready[0] === 1'b1);
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cyc.push_back(c);
        if (issued < 4) begin
          model_op(0, 1'b0, 2'd2, 1'b0, addrs[issued], 32'd0, e, ef);
          exp_q.push_back(e);
          drive(0, 1'b0, 2'd2, 1'b0, addrs[issued], 32'd0);
          issued++;
        end else begin
          req_valid[0] = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    tests++;
    if (got != 4) begin fails++; $display("FAIL b2b_pulses: got %0d want 4", got); end
    tests++;
    if (acc_cyc.size() != 4) begin fails++; $display("FAIL b2b_accepts: got %0d want 4", acc_cyc.size()); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      tests++;
      if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
        fails++; $display("FAIL b2b_spacing%0d: got %0d want 2", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r; logic f;
    bit [1:0] sz; bit [31:0] a;
    for (int k = 0; k < 45; k++) begin
      int d;
      d  = (k < 30) ? 0 : 1;
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 1031));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      do_op(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "random", r, f);
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_store_load();
    test_byte_sign();
    test_faults();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
